stream_to_video_timing: RTL and testbench
=========================================

Name: stream_to_video_timing

Overview:
- Receiving end of the pixel stream (r/g/b, valid, sop, eop) produced by the colour-processing chain.
- Buffers the bursty stream in a pixel FIFO and replays it under a free-running display timing generator with hsync, vsync and de.
- Frame-locks on sop and detects overflow, underflow and misalignment.
- Self-recovers by resynchronising to the next sop.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, clocks.
- H_SYNC, 96: hsync width, clocks.
- H_BP, 48: horizontal back porch, clocks.
- V_ACTIVE, 480: active lines per frame.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vsync width, lines.
- V_BP, 33: vertical back porch, lines.
- SYNC_POL, 0: sync asserted level (0 = active-low sync).
- FIFO_AW, 11: FIFO address width; depth is 2^FIFO_AW words.
- PRIME_LEVEL, 1024: FIFO fill needed before timing starts; must be < 2^FIFO_AW.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous active-low reset.
- r_in, input, 8: red.
- g_in, input, 8: green.
- b_in, input, 8: blue.
- valid_in, input, 1: pixel qualifier. No backpressure.
- sop_in, input, 1: first pixel of frame; valid only with valid_in.
- eop_in, input, 1: last pixel of frame; valid only with valid_in.
- r_out, output, 8: red to display; 0 outside de.
- g_out, output, 8: green to display; 0 outside de.
- b_out, output, 8: blue to display; 0 outside de.
- de_out, output, 1: active video.
- hsync_out, output, 1: horizontal sync.
- vsync_out, output, 1: vertical sync.
- frame_start, output, 1: one-clock pulse aligned with first de of a frame.
- locked, output, 1: state == RUN.
- status, output, 3: sticky flags {misalign, underflow, overflow}.
- status_clr, input, 1: synchronous clear of status. A clear in the same cycle as a new event leaves that flag set.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, state WAIT_SOP, h_cnt=v_cnt=0.
  - All pixel, de and frame_start outputs 0; hsync_out/vsync_out = ~SYNC_POL; locked=0; status=0.
- FIFO word: {sop, eop, r, g, b}, 26 bits. Writes only when valid_in is high and the write is enabled.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
- Position (h_cnt, v_cnt):
  - Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hsync asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule on v_cnt for the whole line.
- Counters: h_cnt wraps at H_TOTAL-1 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- State machine:
  - WAIT_SOP:
    - Write disabled except that a valid_in&sop_in word is written; that cycle moves to PRIME.
    - Counters held at 0, outputs blank.
  - PRIME:
    - Writes enabled; counters held at 0.
    - When fifo level >= PRIME_LEVEL, move to RUN. Counters start the next clock.
  - RUN:
    - Counters free-run.
    - Each active position pops one word.
    - The popped word is checked:
      - at (0,0), sop must be 1;
      - at (H_ACTIVE-1, V_ACTIVE-1), eop must be 1;
      - elsewhere, sop and eop must both be 0.
- Error handling, all events in RUN; each causes a synchronous flush (FIFO emptied, counters to 0, state WAIT_SOP next clock):
  - Check failure: set misalign. The offending pixel is still output.
  - Active position with empty FIFO: set underflow; output 0 for that position.
  - valid_in while FIFO full (in PRIME or RUN): drop the word and set overflow.
  - When overflow and underflow occur in the same cycle, set both flags and flush once.
- Flush priority: an incoming valid&sop word in the flush cycle is not written. Lock requires a later sop.
- Simultaneous read and write on a non-empty FIFO leaves the level unchanged. A write to a full FIFO is not rescued by a same-cycle read; it still counts as overflow.
- Latency: position to outputs is 2 clocks (FIFO read register, then output register). r/g/b, de, hsync, vsync and frame_start stay mutually aligned.
- Outside RUN, and for 2 clocks after leaving it: de_out=0, rgb=0, syncs inactive.
- Input pixels arriving while in WAIT_SOP without sop are discarded silently; no flag is set.

Test Plan:
- Bench parameters: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, FIFO_AW=5, PRIME_LEVEL=8.
- Reset mid-frame:
  - Stimulus: assert rst low during RUN.
  - Response: outputs immediately go to reset values and status=0; after release, state WAIT_SOP.
- Nominal lock:
  - Stimulus: 3 frames of 32 pixels, pixel value = index (r=g=b=i), with sop/eop correct and gaps no longer than the blanking.
  - Response: locked rises after 8 words; frame_start pulses 2 clocks after the counters start; de_out shows 4 runs of 8 per frame; rgb sequence 0..31 each frame; hsync low for 2 clocks per 12-clock line; status=000.
- Pre-sop garbage:
  - Stimulus: 5 valid words without sop, then a valid frame.
  - Response: the 5 words never appear on the output; status=000.
- Underflow:
  - Stimulus: stop valid_in after 20 pixels of frame 2.
  - Response: first starved active position outputs rgb=0 with de=1; status=010; locked falls; relock on the next sop.
- Misalign:
  - Stimulus: sop_in asserted on pixel 5 of a frame.
  - Response: status=100, flush, relock on the next sop; status_clr returns status to 000.
- Overflow:
  - Stimulus: feed 40 continuous pixels in PRIME with PRIME_LEVEL forced unreachable via a 32-deep FIFO and slow timing.
  - Response: word 33 is dropped; status=001; state WAIT_SOP.

Source files
------------

// File: rtl/stream_to_video_timing.sv
// stream_to_video_timing: buffers a bursty sop/eop pixel stream and replays it under a free-running display timing generator
module stream_to_video_timing #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   FIFO_AW     = 11,
  parameter int   PRIME_LEVEL = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       valid_in,
  input  logic       sop_in,
  input  logic       eop_in,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_start,
  output logic       locked,
  output logic [2:0] status,
  input  logic       status_clr
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_S0   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_S1   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_S0   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_S1   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);
  localparam logic [FIFO_AW:0] L_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] L_PRIME = (FIFO_AW + 1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {WAIT_SOP, PRIME, RUN} state_t;

  state_t             r_state, w_next;
  logic [25:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic [HW-1:0]      r_h;
  logic [VW-1:0]      r_v;
  logic [23:0]        r_p1_rgb;
  logic               r_p1_de, r_p1_hs, r_p1_vs, r_p1_fs;
  logic [25:0]        w_word;
  logic               w_run, w_active, w_empty, w_full, w_rd, w_wr;
  logic               w_first, w_last, w_mis, w_unf, w_ovf, w_flush;

  assign w_run    = r_state == RUN;
  assign w_active = w_run && r_h < H_ACT && r_v < V_ACT;
  assign w_empty  = r_level == '0;
  assign w_full   = r_level == L_FULL;
  assign w_rd     = w_active && !w_empty;
  assign w_word   = r_mem[r_rd_ptr];
  assign w_first  = r_h == '0 && r_v == '0;
  assign w_last   = r_h == H_LAST && r_v == V_LAST;
  assign w_mis    = w_rd && (w_first ? !w_word[25] : w_last ? !w_word[24] : (w_word[25] | w_word[24]));
  assign w_unf    = w_active && w_empty;
  assign w_ovf    = valid_in && w_full && r_state != WAIT_SOP;
  assign w_flush  = w_mis | w_unf | w_ovf;
  // a flush beats any write, and before lock only a sop word may enter
  assign w_wr     = valid_in && !w_full && !w_flush && (r_state != WAIT_SOP || sop_in);
  assign locked   = w_run;

  // lock sequence: sop starts priming, enough fill starts timing, any error drops back
  always_comb begin
    w_next = w_flush ? WAIT_SOP :
             (r_state == WAIT_SOP && w_wr) ? PRIME :
             (r_state == PRIME && r_level >= L_PRIME) ? RUN : r_state;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= WAIT_SOP;
    else      r_state <= w_next;
  end

  // fifo storage, unreset so it can map onto plain memory
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {sop_in, eop_in, r_in, g_in, b_in};
  end

  // fifo pointers and fill level, emptied wholesale on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + FIFO_AW'(w_wr);
      r_rd_ptr <= r_rd_ptr + FIFO_AW'(w_rd);
      r_level  <= r_level + (FIFO_AW + 1)'(w_wr) - (FIFO_AW + 1)'(w_rd);
    end
  end

  // raster position, held at origin until locked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!w_run || w_flush) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= r_h == H_END ? '0 : r_h + 1'b1;
      r_v <= r_h != H_END ? r_v : r_v == V_END ? '0 : r_v + 1'b1;
    end
  end

  // two-stage pipe: fifo read register then output register, keeping video and syncs aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1_rgb    <= '0;
      r_p1_de     <= 1'b0;
      r_p1_hs     <= ~SYNC_POL;
      r_p1_vs     <= ~SYNC_POL;
      r_p1_fs     <= 1'b0;
      {r_out, g_out, b_out} <= '0;
      de_out      <= 1'b0;
      hsync_out   <= ~SYNC_POL;
      vsync_out   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      r_p1_rgb    <= w_rd ? w_word[23:0] : '0;
      r_p1_de     <= w_active;
      r_p1_hs     <= (w_run && r_h >= H_S0 && r_h < H_S1) ? SYNC_POL : ~SYNC_POL;
      r_p1_vs     <= (w_run && r_v >= V_S0 && r_v < V_S1) ? SYNC_POL : ~SYNC_POL;
      r_p1_fs     <= w_active && w_first;
      {r_out, g_out, b_out} <= r_p1_rgb;
      de_out      <= r_p1_de;
      hsync_out   <= r_p1_hs;
      vsync_out   <= r_p1_vs;
      frame_start <= r_p1_fs;
    end
  end

  // sticky error flags; a same-cycle event wins over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status <= '0;
    else      status <= (status_clr ? 3'b000 : status) | {w_mis, w_unf, w_ovf};
  end
endmodule

// File: tb/tb_stream_to_video_timing.sv
// tb_stream_to_video_timing: scoreboard bench for the stream-to-display timing bridge
module tb_stream_to_video_timing;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic       valid_in = 1'b0, sop_in = 1'b0, eop_in = 1'b0, status_clr = 1'b0;
  logic [7:0] r_out, g_out, b_out;
  logic       de_out, hsync_out, vsync_out, frame_start, locked;
  logic [2:0] status;
  logic       valid2 = 1'b0, sop2 = 1'b0;
  logic [7:0] r2, g2, b2;
  logic       de2, hs2, vs2, fs2, lk2;
  logic [2:0] st2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int de2_seen = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  always #5 clk = ~clk;

  stream_to_video_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .FIFO_AW(5), .PRIME_LEVEL(8)
  ) u_dut (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .valid_in(valid_in), .sop_in(sop_in), .eop_in(eop_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .de_out(de_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_start(frame_start),
    .locked(locked), .status(status), .status_clr(status_clr)
  );

  // prime level above the 32-word depth so the fifo can only fill up
  stream_to_video_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(100),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .FIFO_AW(5), .PRIME_LEVEL(40)
  ) u_ovf (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .valid_in(valid2), .sop_in(sop2), .eop_in(1'b0),
    .r_out(r2), .g_out(g2), .b_out(b2), .de_out(de2),
    .hsync_out(hs2), .vsync_out(vs2), .frame_start(fs2),
    .locked(lk2), .status(st2), .status_clr(1'b0)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (de_out) obs_q.push_back({r_out, g_out, b_out});
    if (de2) de2_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; status_clr = 1'b0;
    valid2 = 1'b0; sop2 = 1'b0; {r_in, g_in, b_in} = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete(); obs_q.delete(); de2_seen = 0;
    @(posedge clk); #1;
  endtask

  // one 84-clock input frame shaped like the display raster; entered at posedge+1
  task automatic feed_frame(input int n_pix, input int bad_sop, input int n_exp);
    int i;
    i = 0;
    for (int c = 0; c < 84; c++) begin
      if ((c % 12) < 8 && (c / 12) < 4 && i < n_pix) begin
        valid_in = 1'b1;
        {r_in, g_in, b_in} = {3{8'(i)}};
        sop_in = (i == 0 || i == bad_sop);
        eop_in = (i == 31);
        if (i < n_exp) exp_q.push_back({3{8'(i)}});
        i++;
      end else begin
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (de_out !== 1'b0) begin n_err++; $display("FAIL rst_de: got %b expected 0", de_out); end
    n_vec++; if ({r_out, g_out, b_out} !== 24'h0) begin n_err++; $display("FAIL rst_rgb: got %h expected 000000", {r_out, g_out, b_out}); end
    n_vec++; if ({hsync_out, vsync_out} !== 2'b11) begin n_err++; $display("FAIL rst_sync: got %b expected 11", {hsync_out, vsync_out}); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs: got %b expected 0", frame_start); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b expected 0", locked); end
    n_vec++; if (status !== 3'b000) begin n_err++; $display("FAIL rst_status: got %b expected 000", status); end
  endtask

  task automatic test_lock();
    int c0, t, h, v;
    logic [3:0] e, o;
    logic [23:0] ep, op;
    apply_reset();
    c0 = cyc;
    fork
      begin
        feed_frame(32, -1, 32); feed_frame(32, -1, 32); feed_frame(32, -1, 32);
      end
      begin
        t = 0;
        while (locked !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        n_vec++; if (cyc - c0 != 9) begin n_err++; $display("FAIL lock_latency: got %0d expected 9", cyc - c0); end
        @(negedge clk);
        n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL fs_early: got %b expected 0", frame_start); end
        @(negedge clk);
        for (int k = 0; k < 84; k++) begin
          h = k % 12; v = k / 12;
          e = {h < 8 && v < 4, !(h >= 9 && h < 11), v != 5, k == 0};
          o = {de_out, hsync_out, vsync_out, frame_start};
          n_vec++; if (o !== e) begin n_err++; $display("FAIL raster k=%0d: got de/hs/vs/fs %b expected %b", k, o, e); end
          @(negedge clk);
        end
      end
    join
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL lock_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ep = exp_q.pop_front(); op = obs_q.pop_front();
      n_vec++; if (op !== ep) begin n_err++; $display("FAIL lock_pixel: got %h expected %h", op, ep); end
    end
    n_vec++; if (status !== 3'b000) begin n_err++; $display("FAIL lock_status: got %b expected 000", status); end
  endtask

  task automatic test_garbage();
    logic [23:0] ep, op;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      valid_in = 1'b1; sop_in = 1'b0; eop_in = 1'b0;
      {r_in, g_in, b_in} = {3{8'(8'hA0 + k)}};
      @(posedge clk); #1;
    end
    feed_frame(32, -1, 32);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL garb_locked: got %b expected 1", locked); end
    n_vec++; if (status !== 3'b000) begin n_err++; $display("FAIL garb_status: got %b expected 000", status); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL garb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ep = exp_q.pop_front(); op = obs_q.pop_front();
      n_vec++; if (op !== ep) begin n_err++; $display("FAIL garb_pixel: got %h expected %h", op, ep); end
    end
  endtask

  task automatic test_underflow();
    logic [23:0] ep, op;
    apply_reset();
    feed_frame(32, -1, 32);
    feed_frame(20, -1, 20);
    exp_q.push_back(24'h0);
    n_vec++; if (status !== 3'b010) begin n_err++; $display("FAIL unf_status: got %b expected 010", status); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL unf_unlock: got %b expected 0", locked); end
    feed_frame(32, -1, 32);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL unf_relock: got %b expected 1", locked); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL unf_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ep = exp_q.pop_front(); op = obs_q.pop_front();
      n_vec++; if (op !== ep) begin n_err++; $display("FAIL unf_pixel: got %h expected %h", op, ep); end
    end
  endtask

  // continues straight on from the relocked, status-010 state left by test_underflow
  task automatic test_reset_mid();
    n_vec++; if ({locked, status} !== 4'b1010) begin n_err++; $display("FAIL mid_pre: got locked/status %b expected 1010", {locked, status}); end
    for (int c = 0; c < 13; c++) begin
      valid_in = c < 8; sop_in = c == 0; eop_in = 1'b0;
      {r_in, g_in, b_in} = {3{8'(c)}};
      @(posedge clk); #1;
    end
    #2;
    n_vec++; if (de_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_de: got %b expected 1", de_out); end
    rst = 1'b0;
    #1;
    n_vec++; if ({de_out, r_out, g_out, b_out} !== 25'h0) begin n_err++; $display("FAIL mid_video: got %h expected 0", {de_out, r_out, g_out, b_out}); end
    n_vec++; if ({hsync_out, vsync_out, frame_start} !== 3'b110) begin n_err++; $display("FAIL mid_sync: got %b expected 110", {hsync_out, vsync_out, frame_start}); end
    n_vec++; if ({locked, status} !== 4'b0000) begin n_err++; $display("FAIL mid_state: got locked/status %b expected 0000", {locked, status}); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({locked, de_out, status} !== 5'b0) begin n_err++; $display("FAIL mid_after: got %b expected 00000", {locked, de_out, status}); end
  endtask

  task automatic test_misalign();
    logic [23:0] ep, op;
    apply_reset();
    feed_frame(32, -1, 32);
    feed_frame(32, 5, 6);
    feed_frame(32, -1, 32);
    n_vec++; if (status !== 3'b100) begin n_err++; $display("FAIL mis_status: got %b expected 100", status); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL mis_relock: got %b expected 1", locked); end
    status_clr = 1'b1;
    @(posedge clk); #1 status_clr = 1'b0;
    n_vec++; if (status !== 3'b000) begin n_err++; $display("FAIL mis_clear: got %b expected 000", status); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mis_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ep = exp_q.pop_front(); op = obs_q.pop_front();
      n_vec++; if (op !== ep) begin n_err++; $display("FAIL mis_pixel: got %h expected %h", op, ep); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      valid2 = 1'b1; sop2 = k == 0;
      {r_in, g_in, b_in} = {3{8'(k)}};
      @(posedge clk); #1;
      if (k == 31) begin
        n_vec++; if ({lk2, st2} !== 4'b0000) begin n_err++; $display("FAIL ovf_full: got locked/status %b expected 0000", {lk2, st2}); end
      end
      if (k == 32) begin
        n_vec++; if ({lk2, st2} !== 4'b0001) begin n_err++; $display("FAIL ovf_word33: got locked/status %b expected 0001", {lk2, st2}); end
      end
    end
    valid2 = 1'b0; sop2 = 1'b0;
    n_vec++; if ({lk2, st2} !== 4'b0001) begin n_err++; $display("FAIL ovf_end: got locked/status %b expected 0001", {lk2, st2}); end
    n_vec++; if (de2_seen != 0) begin n_err++; $display("FAIL ovf_de: got %0d active clocks expected 0", de2_seen); end
    n_vec++; if ({r2, g2, b2, hs2, vs2, fs2} !== {24'h0, 3'b110}) begin n_err++; $display("FAIL ovf_idle: got %h expected %h", {r2, g2, b2, hs2, vs2, fs2}, {24'h0, 3'b110}); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_garbage();
    test_underflow();
    test_reset_mid();
    test_misalign();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
